// File: rtl/irq_ctrl_if.sv
// Data-memory bus seen by the interrupt controller's register window.
// The master drives address/data/strobes and the slave returns load data and the window hit.
interface irq_ctrl_if;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_rdata;
   logic        bus_hit;

   modport master (
      output bus_addr,
      output bus_wdata,
      output bus_we,
      output bus_re,
      input  bus_rdata,
      input  bus_hit
   );

   modport slave (
      input  bus_addr,
      input  bus_wdata,
      input  bus_we,
      input  bus_re,
      output bus_rdata,
      output bus_hit
   );
endinterface

// File: rtl/irq_ctrl.sv
// Machine timer, external interrupt synchroniser and single-request trap FSM.
// Define IRQ_SW_EN to add the msip software interrupt register and the mie_msie port.
module irq_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst,
   irq_ctrl_if.slave   bus,
   input  logic        ext_irq_in,
   input  logic        mstatus_mie,
   input  logic        mie_mtie,
   input  logic        mie_meie,
`ifdef IRQ_SW_EN
   input  logic        mie_msie,
`endif
   input  logic        irq_ack,
   input  logic        is_mret,
   output logic        irq_req,
   output logic [31:0] irq_cause,
   output logic [31:0] mip_out
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StSvc  = 2'd2;

   localparam logic [31:0] CauseExt = 32'h8000_000B;
   localparam logic [31:0] CauseSw  = 32'h8000_0003;
   localparam logic [31:0] CauseTmr = 32'h8000_0007;

   localparam logic [15:0] TickMax = 16'(TICK_DIV - 1);

   logic [31:0] w_off;
   logic        w_hit;
   logic [2:0]  w_idx;
   logic        w_wr;
   logic [31:0] w_rdata;

   logic [15:0] r_presc;
   logic        w_tick;
   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;

   logic        r_sync1;
   logic        r_sync2;
   logic        r_sync3;
   logic        w_ext_rise;
   logic        r_ext_pend;
   logic        w_ext_clr;

   logic        w_tmr_pend;
   logic        w_sw_pend;
   logic        w_sw_en;
   logic        w_eligible;
   logic [31:0] w_cause_sel;

   logic [1:0]  r_state;
   logic [1:0]  w_state_d;
   logic [31:0] r_cause;

   // Window decode: offsets 0x00..0x13 belong to this block.
   assign w_off = bus.bus_addr - BASE_ADDR;
   assign w_hit = (w_off < 32'd20);
   assign w_idx = w_off[4:2];
   assign w_wr  = bus.bus_we & w_hit;

   assign w_tick = (r_presc == TickMax);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc    <= '0;
         r_mtime    <= '0;
         r_mtimecmp <= '1;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 16'd1;
         // A store to either mtime half suppresses that cycle's increment.
         if (w_wr && (w_idx == 3'd0)) begin
            r_mtime[31:0] <= bus.bus_wdata;
         end else if (w_wr && (w_idx == 3'd1)) begin
            r_mtime[63:32] <= bus.bus_wdata;
         end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
         end
         if (w_wr && (w_idx == 3'd2)) begin
            r_mtimecmp[31:0] <= bus.bus_wdata;
         end
         if (w_wr && (w_idx == 3'd3)) begin
            r_mtimecmp[63:32] <= bus.bus_wdata;
         end
      end
   end

`ifdef IRQ_SW_EN
   logic r_msip;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_msip <= 1'b0;
      end else if (w_wr && (w_idx == 3'd4)) begin
         r_msip <= bus.bus_wdata[0];
      end
   end

   assign w_sw_pend = r_msip;
   assign w_sw_en   = mie_msie;
`else
   assign w_sw_pend = 1'b0;
   assign w_sw_en   = 1'b0;
`endif

   always_comb begin
      w_rdata = '0;
      if (bus.bus_re && w_hit) begin
         case (w_idx)
            3'd0:    w_rdata = r_mtime[31:0];
            3'd1:    w_rdata = r_mtime[63:32];
            3'd2:    w_rdata = r_mtimecmp[31:0];
            3'd3:    w_rdata = r_mtimecmp[63:32];
            3'd4:    w_rdata = {31'd0, w_sw_pend};
            default: w_rdata = '0;
         endcase
      end
   end

   assign bus.bus_rdata = w_rdata;
   assign bus.bus_hit   = w_hit;

   // Two-flop synchroniser, third flop only for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= ext_irq_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_ext_rise = r_sync2 & ~r_sync3;
   assign w_ext_clr  = (r_state == StReq) & irq_ack & (r_cause == CauseExt);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ext_pend <= 1'b0;
      end else if (w_ext_rise) begin
         r_ext_pend <= 1'b1;
      end else if (w_ext_clr) begin
         r_ext_pend <= 1'b0;
      end
   end

   assign w_tmr_pend = (r_mtime >= r_mtimecmp);

   assign w_eligible = mstatus_mie & ((r_ext_pend & mie_meie) |
                                      (w_sw_pend & w_sw_en) |
                                      (w_tmr_pend & mie_mtie));

   always_comb begin
      w_cause_sel = CauseTmr;
      if (r_ext_pend && mie_meie) begin
         w_cause_sel = CauseExt;
      end else if (w_sw_pend && w_sw_en) begin
         w_cause_sel = CauseSw;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: if (w_eligible) w_state_d = StReq;
         StReq: begin
            if (irq_ack) begin
               w_state_d = StSvc;
            end else if (!w_eligible) begin
               w_state_d = StIdle;
            end
         end
         StSvc:   if (is_mret) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Cause is captured only on IDLE->REQ so it stays stable for the CSR stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_cause <= '0;
      end else begin
         r_state <= w_state_d;
         if ((r_state == StIdle) && w_eligible) begin
            r_cause <= w_cause_sel;
         end
      end
   end

   assign irq_req   = (r_state == StReq);
   assign irq_cause = r_cause;
   assign mip_out   = {20'd0, r_ext_pend, 3'd0, w_tmr_pend, 3'd0, w_sw_pend, 3'd0};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register-window vector table plus interrupt sequences.
module tb_irq_ctrl;

   localparam logic [31:0] Base = 32'h0000_2000;
`ifdef IRQ_SW_EN
   localparam logic [31:0] ExpMsip = 32'd1;
`else
   localparam logic [31:0] ExpMsip = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ext_irq_in;
   logic        mstatus_mie;
   logic        mie_mtie;
   logic        mie_meie;
`ifdef IRQ_SW_EN
   logic        mie_msie;
`endif
   logic        irq_ack;
   logic        is_mret;
   logic        irq_req;
   logic [31:0] irq_cause;
   logic [31:0] mip_out;

   int n_chk  = 0;
   int n_fail = 0;

   irq_ctrl_if bus_if ();

   irq_ctrl #(
      .BASE_ADDR (Base),
      .TICK_DIV  (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_if),
      .ext_irq_in  (ext_irq_in),
      .mstatus_mie (mstatus_mie),
      .mie_mtie    (mie_mtie),
      .mie_meie    (mie_meie),
`ifdef IRQ_SW_EN
      .mie_msie    (mie_msie),
`endif
      .irq_ack     (irq_ack),
      .is_mret     (is_mret),
      .irq_req     (irq_req),
      .irq_cause   (irq_cause),
      .mip_out     (mip_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      bus_if.bus_addr  = a;
      bus_if.bus_wdata = d;
      bus_if.bus_we    = 1'b1;
      tick();
      bus_if.bus_we    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus_if.bus_addr = a;
      bus_if.bus_re   = 1'b1;
      #1;
      d = bus_if.bus_rdata;
      bus_if.bus_re   = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int          cyc;

      rst = 1'b1;
      ext_irq_in = 1'b0;
      mstatus_mie = 1'b0;
      mie_mtie = 1'b0;
      mie_meie = 1'b0;
`ifdef IRQ_SW_EN
      mie_msie = 1'b0;
`endif
      irq_ack = 1'b0;
      is_mret = 1'b0;
      bus_if.bus_addr = '0;
      bus_if.bus_wdata = '0;
      bus_if.bus_we = 1'b0;
      bus_if.bus_re = 1'b0;

      vecs[0]  = '{1'b1, 1'b0, Base + 32'h08, 32'h1234_5678, 32'h0, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, Base + 32'h08, 32'h0, 32'h1234_5678, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, Base + 32'h0C, 32'hA5A5_0000, 32'h0, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, Base + 32'h0C, 32'h0, 32'hA5A5_0000, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, Base + 32'h04, 32'h0, 32'h0, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, Base + 32'h10, 32'h0, 32'h0, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, Base + 32'h10, 32'h1, 32'h0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, Base + 32'h10, 32'h0, ExpMsip, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, Base + 32'h14, 32'h0, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, Base - 32'h04, 32'h0, 32'h0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, Base + 32'h08, 32'h0, 32'h0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, Base + 32'h10, 32'h0, 32'h0, 1'b1};

      // Reset state
      tick();
      tick();
      chk("rst_req", {31'd0, irq_req}, 32'd0);
      chk("rst_cause", irq_cause, 32'd0);
      chk("rst_mip", mip_out, 32'd0);
      rd(Base + 32'h00, d); chk("rst_mtime_lo", d, 32'd0);
      rd(Base + 32'h08, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
      rd(Base + 32'h0C, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
      rst = 1'b0;

      // Register window vectors
      for (int i = 0; i < 12; i++) begin
         bus_if.bus_we    = vecs[i].we;
         bus_if.bus_re    = vecs[i].re;
         bus_if.bus_addr  = vecs[i].addr;
         bus_if.bus_wdata = vecs[i].wdata;
         #1;
         chk($sformatf("vec%0d_rdata", i), bus_if.bus_rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_hit", i), {31'd0, bus_if.bus_hit}, {31'd0, vecs[i].exp_hit});
         tick();
         bus_if.bus_we = 1'b0;
         bus_if.bus_re = 1'b0;
      end

      // Timer: mtime restarted at 0, compare at 10 -> request 11 clocks after the restart
      bus_wr(Base + 32'h08, 32'd10);
      bus_wr(Base + 32'h0C, 32'd0);
      bus_wr(Base + 32'h00, 32'd0);
      mstatus_mie = 1'b1;
      mie_mtie = 1'b1;
      cyc = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (irq_req) begin
            cyc = n;
            break;
         end
      end
      chk("tmr_latency", cyc, 32'd11);
      rd(Base + 32'h00, d); chk("tmr_mtime_at_req", d, 32'd11);
      chk("tmr_cause", irq_cause, 32'h8000_0007);
      chk("tmr_mip", mip_out, 32'h0000_0080);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("tmr_ack_req", {31'd0, irq_req}, 32'd0);
      bus_wr(Base + 32'h08, 32'd1000);
      is_mret = 1'b1; tick(); is_mret = 1'b0;
      tick(); tick();
      chk("tmr_after_mret_req", {31'd0, irq_req}, 32'd0);
      chk("tmr_after_mret_mip", mip_out, 32'd0);

      // External: four-clock latency, ack clears ext_pend
      mie_meie = 1'b1;
      ext_irq_in = 1'b1;
      tick(); tick(); tick();
      chk("ext_3clk_req", {31'd0, irq_req}, 32'd0);
      chk("ext_3clk_mip", mip_out, 32'h0000_0800);
      tick();
      chk("ext_4clk_req", {31'd0, irq_req}, 32'd1);
      chk("ext_cause", irq_cause, 32'h8000_000B);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("ext_ack_mip", mip_out, 32'd0);
      chk("ext_ack_req", {31'd0, irq_req}, 32'd0);
      is_mret = 1'b1; tick(); is_mret = 1'b0;
      ext_irq_in = 1'b0;
      tick();
      chk("ext_idle_req", {31'd0, irq_req}, 32'd0);

      // Timer and external together: external wins, timer follows after mret
      mstatus_mie = 1'b0;
      bus_wr(Base + 32'h08, 32'd0);
      tick(); tick(); tick();
      ext_irq_in = 1'b1;
      tick(); tick(); tick();
      chk("both_mip", mip_out, 32'h0000_0880);
      mstatus_mie = 1'b1;
      tick();
      chk("both_req", {31'd0, irq_req}, 32'd1);
      chk("both_cause_ext", irq_cause, 32'h8000_000B);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("both_svc_req", {31'd0, irq_req}, 32'd0);
      chk("both_svc_mip", mip_out, 32'h0000_0080);
      is_mret = 1'b1; tick(); is_mret = 1'b0;
      chk("both_mret_req", {31'd0, irq_req}, 32'd0);
      tick();
      chk("both_tmr_req", {31'd0, irq_req}, 32'd1);
      chk("both_cause_tmr", irq_cause, 32'h8000_0007);

      // REQ holds cause against a new higher-priority source; mret in REQ is ignored
      ext_irq_in = 1'b0;
      tick(); tick(); tick();
      ext_irq_in = 1'b1;
      tick(); tick(); tick();
      chk("hold_cause", irq_cause, 32'h8000_0007);
      chk("hold_mip", mip_out, 32'h0000_0880);
      is_mret = 1'b1; tick(); is_mret = 1'b0;
      chk("mret_in_req", {31'd0, irq_req}, 32'd1);

      // Mask drop without ack, then re-enable
      mstatus_mie = 1'b0;
      tick();
      chk("drop_req", {31'd0, irq_req}, 32'd0);
      mstatus_mie = 1'b1;
      tick();
      chk("reen_req", {31'd0, irq_req}, 32'd1);
      chk("reen_cause", irq_cause, 32'h8000_000B);

      // Ack beats a simultaneous mask drop; ack in SVC is ignored
      irq_ack = 1'b1;
      mstatus_mie = 1'b0;
      tick();
      irq_ack = 1'b0;
      mstatus_mie = 1'b1;
      tick();
      chk("ackdrop_svc_req", {31'd0, irq_req}, 32'd0);
      chk("ackdrop_mip", mip_out, 32'h0000_0080);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      tick();
      chk("ack_in_svc", {31'd0, irq_req}, 32'd0);
      is_mret = 1'b1; tick(); is_mret = 1'b0;
      tick();
      chk("svc_mret_tmr_req", {31'd0, irq_req}, 32'd1);
      chk("svc_mret_tmr_cause", irq_cause, 32'h8000_0007);
      mstatus_mie = 1'b0;
      bus_wr(Base + 32'h0C, 32'hFFFF_FFFF);
      tick();
      chk("cmp_raise_req", {31'd0, irq_req}, 32'd0);

      // mtime carry across halves and write-over-tick
      bus_wr(Base + 32'h00, 32'hFFFF_FFFF);
      bus_wr(Base + 32'h04, 32'd0);
      rd(Base + 32'h00, d); chk("wrap_pre_lo", d, 32'hFFFF_FFFF);
      rd(Base + 32'h04, d); chk("wrap_pre_hi", d, 32'd0);
      tick();
      rd(Base + 32'h00, d); chk("wrap_lo", d, 32'd0);
      rd(Base + 32'h04, d); chk("wrap_hi", d, 32'd1);
      bus_wr(Base + 32'h00, 32'h55);
      rd(Base + 32'h00, d); chk("wr_on_tick_lo", d, 32'h55);
      bus_wr(Base + 32'h04, 32'd7);
      rd(Base + 32'h00, d); chk("hi_wr_no_inc_lo", d, 32'h55);
      rd(Base + 32'h04, d); chk("hi_wr_hi", d, 32'd7);

      // Reset mid-operation drops a pending external interrupt
      ext_irq_in = 1'b0;
      tick(); tick(); tick();
      ext_irq_in = 1'b1;
      tick(); tick(); tick();
      chk("pre_rst_mip", mip_out, 32'h0000_0800);
      rst = 1'b1;
      ext_irq_in = 1'b0;
      tick();
      chk("mid_rst_mip", mip_out, 32'd0);
      chk("mid_rst_req", {31'd0, irq_req}, 32'd0);
      chk("mid_rst_cause", irq_cause, 32'd0);
      rd(Base + 32'h00, d); chk("mid_rst_mtime", d, 32'd0);
      rd(Base + 32'h0C, d); chk("mid_rst_cmp_hi", d, 32'hFFFF_FFFF);
      rst = 1'b0;
      tick();

`ifdef IRQ_SW_EN
      // Software interrupt through msip
      mstatus_mie = 1'b1;
      mie_msie = 1'b1;
      bus_wr(Base + 32'h10, 32'd1);
      chk("sw_mip", mip_out, 32'h0000_0008);
      chk("sw_pre_req", {31'd0, irq_req}, 32'd0);
      tick();
      chk("sw_req", {31'd0, irq_req}, 32'd1);
      chk("sw_cause", irq_cause, 32'h8000_0003);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
